// File: rtl/bk_adder_arbiter.sv
// ---------------------------------------------------------------------------
// bk_adder_arbiter
// Shares a single Brent-Kung 32-bit adder among NREQ requesters.
// Requests are granted round-robin. A 64-bit add takes two adder passes: the
// low word first, then the high word with the carry from the low pass.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid                       [NREQ]
//   req_ready  per-requester accept, one-hot or zero             [NREQ]
//   req_a      operand A, slice i = [64*i+63:64*i]               [NREQ*64]
//   req_b      operand B, same slicing as req_a                  [NREQ*64]
//   req_cin    per-requester carry-in                            [NREQ]
//   req_wide   1 = 64-bit add, 0 = 32-bit add on low words       [NREQ]
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_id     index of the requester that was served            [IDW]
//   rsp_sum    result; upper word is zero for 32-bit ops         [64]
//   rsp_cout   carry out of bit 31 (32-bit op) or bit 63 (64-bit op)
//   busy       high in every state except IDLE
// ---------------------------------------------------------------------------

// Purely combinational 32-bit Brent-Kung prefix adder.
module brentkung32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // Returns {cout, sum}. cin is folded into the bit-0 generate, so the
    // prefix generate at bit i is the carry out of bit i.
    function automatic logic [32:0] bk_add(input logic [31:0] op_a,
                                           input logic [31:0] op_b,
                                           input logic        c_in);
        logic [31:0] g_v;
        logic [31:0] p_v;
        logic [31:0] gg_v;
        logic [31:0] pp_v;
        logic [31:0] s_v;
        g_v  = op_a & op_b;
        p_v  = op_a ^ op_b;
        gg_v = g_v;
        pp_v = p_v;
        gg_v[0] = g_v[0] | (p_v[0] & c_in);
        // Up-sweep: build group (g,p) over aligned blocks of 2,4,..,32 bits.
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (((i + 1) % (1 << (l + 1))) == 0) begin
                    gg_v[i] = gg_v[i] | (pp_v[i] & gg_v[i - (1 << l)]);
                    pp_v[i] = pp_v[i] & pp_v[i - (1 << l)];
                end
            end
        end
        // Down-sweep: fill in the remaining prefixes from the block boundaries.
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < 32; i++) begin
                if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i > (1 << l))) begin
                    gg_v[i] = gg_v[i] | (pp_v[i] & gg_v[i - (1 << l)]);
                    pp_v[i] = pp_v[i] & pp_v[i - (1 << l)];
                end
            end
        end
        s_v[0] = p_v[0] ^ c_in;
        for (int i = 1; i < 32; i++) begin
            s_v[i] = p_v[i] ^ gg_v[i - 1];
        end
        return {gg_v[31], s_v};
    endfunction

    logic [32:0] res_s;

    // Evaluate the prefix adder.
    always_comb begin
        res_s = bk_add(a, b, cin);
        sum   = res_s[31:0];
        cout  = res_s[32];
    end

endmodule

module bk_adder_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*64-1:0] req_a,
    input  logic [NREQ*64-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_wide,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [63:0]       rsp_sum,
    output logic              rsp_cout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD_LO = 2'd1,
        ADD_HI = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  gnt_r;
    logic [63:0]     a_r;
    logic [63:0]     b_r;
    logic            cin_r;
    logic            wide_r;
    logic [31:0]     sum_lo_r;
    logic [31:0]     sum_hi_r;
    logic            carry_r;
    logic            rsp_valid_r;
    logic            busy_r;

    logic            gnt_found_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic [IDW-1:0]  scan_idx_s;
    logic [NREQ-1:0] ready_s;
    logic [31:0]     add_a_s;
    logic [31:0]     add_b_s;
    logic            add_cin_s;
    logic [31:0]     add_sum_s;
    logic            add_cout_s;

    // Round-robin search from the pointer; the IDW-bit add wraps modulo NREQ
    // because NREQ is a power of two.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        scan_idx_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx_s = ptr_r + IDW'(i);
            if (!gnt_found_s && req_valid[scan_idx_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = scan_idx_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Accept strobe: only in IDLE, one-hot on the granted requester.
    always_comb begin
        ready_s = '0;
        if ((state_r == IDLE) && gnt_found_s) begin
            ready_s[gnt_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Adder operand mux; operands are held at zero outside the add passes.
    always_comb begin
        add_a_s   = 32'h0000_0000;
        add_b_s   = 32'h0000_0000;
        add_cin_s = 1'b0;
        case (state_r)
            ADD_LO: begin
                add_a_s   = a_r[31:0];
                add_b_s   = b_r[31:0];
                add_cin_s = cin_r;
            end
            ADD_HI: begin
                add_a_s   = a_r[63:32];
                add_b_s   = b_r[63:32];
                add_cin_s = carry_r;
            end
            default: begin
                add_a_s   = 32'h0000_0000;
                add_b_s   = 32'h0000_0000;
                add_cin_s = 1'b0;
            end
        endcase
    end

    brentkung32 u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Scheduler FSM with captured request and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            gnt_r       <= '0;
            a_r         <= 64'h0;
            b_r         <= 64'h0;
            cin_r       <= 1'b0;
            wide_r      <= 1'b0;
            sum_lo_r    <= 32'h0;
            sum_hi_r    <= 32'h0;
            carry_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_found_s) begin
                        a_r      <= req_a[gnt_idx_s*64 +: 64];
                        b_r      <= req_b[gnt_idx_s*64 +: 64];
                        cin_r    <= req_cin[gnt_idx_s];
                        wide_r   <= req_wide[gnt_idx_s];
                        gnt_r    <= gnt_idx_s;
                        // Narrow ops never write the high word, so clear it now.
                        sum_hi_r <= 32'h0;
                        busy_r   <= 1'b1;
                        state_r  <= ADD_LO;
                    end
                end
                ADD_LO: begin
                    sum_lo_r <= add_sum_s;
                    carry_r  <= add_cout_s;
                    if (wide_r) begin
                        state_r <= ADD_HI;
                    end else begin
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end
                end
                ADD_HI: begin
                    sum_hi_r    <= add_sum_s;
                    carry_r     <= add_cout_s;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        ptr_r       <= gnt_r + IDW'(1);
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = gnt_r;
    assign rsp_sum   = {sum_hi_r, sum_lo_r};
    assign rsp_cout  = carry_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bk_adder_arbiter
// Directed self-checking bench for bk_adder_arbiter (NREQ = 4).
// ---------------------------------------------------------------------------
module tb_bk_adder_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [3:0]   req_cin;
    logic [3:0]   req_wide;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_sum;
    logic         rsp_cout;
    logic         busy;

    int checks;
    int failures;

    bk_adder_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_wide  (req_wide),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_ready"}, {60'd0, req_ready}, 64'd0);
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_id"},    {62'd0, rsp_id},    64'd0);
        chk({tag, "_rsp_sum"},   rsp_sum,            64'd0);
        chk({tag, "_rsp_cout"},  {63'd0, rsp_cout},  64'd0);
        chk({tag, "_busy"},      {63'd0, busy},      64'd0);
    endtask

    // One request from a single requester with rsp_ready held high; checks
    // grant, exact latency, response fields and return to idle.
    task automatic do_op(input string tag, input int id,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic wide,
                         input logic [63:0] exp_sum, input logic exp_cout);
        logic [3:0] onehot;
        onehot = 4'b0001 << id;
        req_valid = onehot;
        req_a[id*64 +: 64] = a;
        req_b[id*64 +: 64] = b;
        req_cin[id]  = cin;
        req_wide[id] = wide;
        rsp_ready = 1'b1;
        #1;
        chk({tag, "_grant"}, {60'd0, req_ready}, {60'd0, onehot});
        tick;
        req_valid = 4'b0000;
        #1;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, "_early_valid"}, {63'd0, rsp_valid}, 64'd0);
        if (wide) begin
            tick;
            chk({tag, "_early_valid_hi"}, {63'd0, rsp_valid}, 64'd0);
        end
        tick;
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        chk({tag, "_rsp_id"},   {62'd0, rsp_id}, 64'(id));
        chk({tag, "_rsp_sum"},  rsp_sum, exp_sum);
        chk({tag, "_rsp_cout"}, {63'd0, rsp_cout}, {63'd0, exp_cout});
        tick;
        chk({tag, "_done"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    logic [63:0] held_sum;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_a     = 256'd0;
        req_b     = 256'd0;
        req_cin   = 4'b0000;
        req_wide  = 4'b0000;
        rsp_ready = 1'b1;

        // Reset state.
        tick;
        tick;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        tick;

        // 32-bit carry out (ptr 0 -> 1).
        do_op("carry32", 0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
              64'h0000_0000_0000_0000, 1'b1);
        // Low-to-high carry (ptr -> 3).
        do_op("lohi", 2, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1,
              64'h0000_0001_0000_0000, 1'b0);
        // Full 64-bit wrap via cin (ptr -> 0).
        do_op("wrap64", 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1,
              64'h0, 1'b1);
        // Narrow op ignores the upper operand words (ptr -> 2).
        do_op("narrow", 1, 64'hDEAD_BEEF_1234_5678, 64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0,
              64'h0000_0000_9999_999A, 1'b0);
        // Wide op with carry into a sign-bit high word (ptr -> 3).
        do_op("wide_mid", 2, 64'h7FFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 1'b0, 1'b1,
              64'h8000_0000_0000_0000, 1'b0);
        // Alternating bits plus cin (ptr -> 0).
        do_op("alt", 3, 64'h0000_0000_AAAA_AAAA, 64'h0000_0000_5555_5555, 1'b1, 1'b0,
              64'h0, 1'b1);

        // Round-robin fairness: all requesters valid, grant order 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            req_a[i*64 +: 64] = 64'(i);
            req_b[i*64 +: 64] = 64'h10;
        end
        req_cin   = 4'b0000;
        req_wide  = 4'b0000;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", {60'd0, req_ready}, {60'd0, 4'b0001 << (k % 4)});
            tick;
            chk("rr_ready_low", {60'd0, req_ready}, 64'd0);
            tick;
            chk("rr_rsp_id",  {62'd0, rsp_id}, 64'(k % 4));
            chk("rr_rsp_sum", rsp_sum, 64'h10 + 64'(k % 4));
            tick;
        end
        req_valid = 4'b0000;
        tick;

        // Backpressure on requester 1 (ptr is 1); others stay valid throughout.
        req_a[64 +: 64] = 64'h5;
        req_b[64 +: 64] = 64'h7;
        req_cin[1]      = 1'b1;
        req_valid       = 4'b0010;
        rsp_ready       = 1'b0;
        #1;
        chk("bp_grant", {60'd0, req_ready}, 64'h2);
        tick;
        req_valid = 4'b1111;
        tick;
        held_sum = 64'hD;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_sum",   rsp_sum, held_sum);
            chk("bp_id",    {62'd0, rsp_id}, 64'd1);
            chk("bp_ready", {60'd0, req_ready}, 64'd0);
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_last_valid", {63'd0, rsp_valid}, 64'd1);
        tick;
        chk("bp_done", {63'd0, rsp_valid}, 64'd0);
        chk("bp_next_grant", {60'd0, req_ready}, 64'h4);
        req_valid = 4'b0000;
        tick;

        // Reset during ADD_HI of a wide op on requester 3 (ptr is 2).
        req_a[192 +: 64] = 64'h1234_5678_9ABC_DEF0;
        req_b[192 +: 64] = 64'h1111_1111_1111_1111;
        req_wide[3]      = 1'b1;
        req_cin[3]       = 1'b0;
        req_valid        = 4'b1000;
        #1;
        chk("rst_grant", {60'd0, req_ready}, 64'h8);
        tick;
        req_valid = 4'b0000;
        tick;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_mid");
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("rst_no_stale", {63'd0, rsp_valid}, 64'd0);
        end
        req_valid = 4'b1111;
        #1;
        chk("rst_grant_from0", {60'd0, req_ready}, 64'h1);
        tick;
        req_valid = 4'b0000;
        tick;
        chk("rst_after_id",  {62'd0, rsp_id}, 64'd0);
        chk("rst_after_sum", rsp_sum, 64'h10);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
